// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-port arbiter (WB fixed priority, A/B round-robin) with starvation stall.
// Optional pending-write scoreboard enabled by WBARB_SCOREBOARD_EN.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int REG_NUM    = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              a_valid_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              pipe_stall_o,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  input  logic [ADDR_W-1:0] chk_addr1_i,
  input  logic [ADDR_W-1:0] chk_addr2_i,
  output logic              busy1_o,
  output logic              busy2_o
);
  typedef enum logic {NORMAL, STALL} state_e;
  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_inc;
  logic              rr_q;
  logic              wb_gnt, a_gnt, b_gnt, hs;
  logic [ADDR_W-1:0] hs_addr, win_addr;
  logic [DATA_W-1:0] hs_data;
  // Grants are masked while in reset so held requests are not handshaken.
  assign wb_gnt   = rst_n & wb_valid_i;
  assign a_gnt    = rst_n & ~wb_valid_i & a_valid_i & (~b_valid_i | ~rr_q);
  assign b_gnt    = rst_n & ~wb_valid_i & b_valid_i & ~a_gnt;
  assign hs       = a_gnt | b_gnt;
  assign hs_addr  = a_gnt ? a_addr_i : b_addr_i;
  assign hs_data  = a_gnt ? a_data_i : b_data_i;
  assign win_addr = wb_gnt ? wb_addr_i : hs ? hs_addr : '0;
  assign a_ready_o    = a_gnt;
  assign b_ready_o    = b_gnt;
  assign rf_waddr_o   = win_addr;
  assign rf_wdata_o   = wb_gnt ? wb_data_i : hs ? hs_data : '0;
  assign rf_we_o      = win_addr != '0;
  assign pipe_stall_o = state_q == STALL;
  assign cnt_inc      = cnt_q + 4'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      if (hs) rr_q <= a_gnt;
      case (state_q)
        NORMAL: begin
          if (hs || !(a_valid_i || b_valid_i)) cnt_q <= '0;
          else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == 4'(STARVE_MAX)) state_q <= STALL;
          end
        end
        default: begin
          if (hs) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end
`ifdef WBARB_SCOREBOARD_EN
  logic [REG_NUM-1:0] busy_q, busy_d;
  // Set after clear so a same-cycle issue to a committing register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (hs) busy_d[hs_addr] = 1'b0;
    if (iss_valid_i && iss_addr_i != '0) busy_d[iss_addr_i] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else busy_q <= busy_d;
  end
  assign busy1_o = chk_addr1_i != '0 && busy_q[chk_addr1_i] && !(hs && hs_addr == chk_addr1_i);
  assign busy2_o = chk_addr2_i != '0 && busy_q[chk_addr2_i] && !(hs && hs_addr == chk_addr2_i);
`else
  localparam int unused_reg_num = REG_NUM;
  logic unused_iss;
  assign unused_iss = ^{iss_valid_i, iss_addr_i, chk_addr1_i, chk_addr2_i};
  assign busy1_o = 1'b0;
  assign busy2_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (STARVE_MAX=4).
module tb_wb_arbiter;
`ifdef WBARB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid_i, a_valid_i, b_valid_i, iss_valid_i;
  logic [4:0]  wb_addr_i, a_addr_i, b_addr_i, iss_addr_i, chk_addr1_i, chk_addr2_i;
  logic [31:0] wb_data_i, a_data_i, b_data_i;
  logic        a_ready_o, b_ready_o, rf_we_o, pipe_stall_o, busy1_o, busy2_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  int checks = 0;
  int failures = 0;

  wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .pipe_stall_o(pipe_stall_o),
    .iss_valid_i(iss_valid_i), .iss_addr_i(iss_addr_i),
    .chk_addr1_i(chk_addr1_i), .chk_addr2_i(chk_addr2_i),
    .busy1_o(busy1_o), .busy2_o(busy2_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic port(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ar, input logic br);
    chk({tag, ".we"}, 32'(rf_we_o), 32'(we));
    chk({tag, ".waddr"}, 32'(rf_waddr_o), 32'(wa));
    chk({tag, ".wdata"}, rf_wdata_o, wd);
    chk({tag, ".a_ready"}, 32'(a_ready_o), 32'(ar));
    chk({tag, ".b_ready"}, 32'(b_ready_o), 32'(br));
  endtask

  initial begin
    rst_n = 1'b0;
    {wb_valid_i, a_valid_i, b_valid_i, iss_valid_i} = '0;
    {wb_addr_i, a_addr_i, b_addr_i, iss_addr_i, chk_addr1_i, chk_addr2_i} = '0;
    {wb_data_i, a_data_i, b_data_i} = '0;
    a_valid_i = 1'b1; a_addr_i = 5'd2; a_data_i = 32'hAA;
    cyc(); cyc();
    port("reset_held_a", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("reset.stall", 32'(pipe_stall_o), 32'h0);
    chk("reset.busy1", 32'(busy1_o), 32'h0);
    a_valid_i = 1'b0;
    #2 rst_n = 1'b1;
    cyc();
    port("idle", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("idle.stall", 32'(pipe_stall_o), 32'h0);
    // collision: WB wins, then A (rr starts at A), then B
    wb_valid_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h11;
    a_valid_i = 1'b1; a_addr_i = 5'd4; a_data_i = 32'h22;
    b_valid_i = 1'b1; b_addr_i = 5'd5; b_data_i = 32'h33;
    #1 port("coll0", 1'b1, 5'd3, 32'h11, 1'b0, 1'b0);
    cyc(); wb_valid_i = 1'b0;
    #1 port("coll1", 1'b1, 5'd4, 32'h22, 1'b1, 1'b0);
    cyc(); a_valid_i = 1'b0;
    #1 port("coll2", 1'b1, 5'd5, 32'h33, 1'b0, 1'b1);
    // round robin, pointer back at A
    cyc();
    a_valid_i = 1'b1; a_addr_i = 5'd6; a_data_i = 32'h44;
    b_valid_i = 1'b1; b_addr_i = 5'd8; b_data_i = 32'h55;
    #1 port("rr0", 1'b1, 5'd6, 32'h44, 1'b1, 1'b0);
    cyc(); #1 port("rr1", 1'b1, 5'd8, 32'h55, 1'b0, 1'b1);
    cyc(); #1 port("rr2", 1'b1, 5'd6, 32'h44, 1'b1, 1'b0);
    cyc(); #1 port("rr3", 1'b1, 5'd8, 32'h55, 1'b0, 1'b1);
    cyc(); a_valid_i = 1'b0; b_valid_i = 1'b0;
    #1 port("idle2", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    // starvation: four lost cycles, then stall
    cyc();
    wb_valid_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = 32'h77;
    a_valid_i = 1'b1; a_addr_i = 5'd9; a_data_i = 32'h99;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("starve%0d.stall", i), 32'(pipe_stall_o), 32'h0);
      chk($sformatf("starve%0d.a_ready", i), 32'(a_ready_o), 32'h0);
      cyc();
    end
    #1 chk("starve4.stall", 32'(pipe_stall_o), 32'h1);
    port("starve4", 1'b1, 5'd1, 32'h77, 1'b0, 1'b0);
    cyc(); wb_valid_i = 1'b0;
    #1 port("drain", 1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
    chk("drain.stall", 32'(pipe_stall_o), 32'h1);
    cyc(); a_valid_i = 1'b0;
    #1 chk("after_drain.stall", 32'(pipe_stall_o), 32'h0);
    // r0 write completes handshake without write enable
    chk_addr1_i = 5'd7;
    a_valid_i = 1'b1; a_addr_i = 5'd0; a_data_i = 32'hFFFF_FFFF;
    #1 port("r0", 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("r0.busy1", 32'(busy1_o), 32'h0);
    // scoreboard
    cyc(); a_valid_i = 1'b0;
    iss_valid_i = 1'b1; iss_addr_i = 5'd7; chk_addr2_i = 5'd0;
    #1 chk("iss.busy1_same", 32'(busy1_o), 32'h0);
    cyc(); iss_valid_i = 1'b0;
    #1 chk("iss.busy1", 32'(busy1_o), 32'(SB));
    chk("iss.busy2_r0", 32'(busy2_o), 32'h0);
    cyc();
    b_valid_i = 1'b1; b_addr_i = 5'd7; b_data_i = 32'h1234;
    #1 port("bcommit", 1'b1, 5'd7, 32'h1234, 1'b0, 1'b1);
    chk("bcommit.busy1", 32'(busy1_o), 32'h0);
    cyc(); b_valid_i = 1'b0;
    #1 chk("cleared.busy1", 32'(busy1_o), 32'h0);
    cyc();
    iss_valid_i = 1'b1; iss_addr_i = 5'd7;
    b_valid_i = 1'b1; b_addr_i = 5'd7; b_data_i = 32'h5678;
    #1 chk("setclr.busy1_same", 32'(busy1_o), 32'h0);
    chk("setclr.b_ready", 32'(b_ready_o), 32'h1);
    cyc(); iss_valid_i = 1'b0; b_valid_i = 1'b0;
    #1 chk("setwins.busy1", 32'(busy1_o), 32'(SB));
    port("final_idle", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
